// File: rtl/rggen_native_initiator_pkg.sv
// Shared encodings and helpers for the rggen native-bus initiator.
// Access and status codes follow the rggen native CSR bus definitions.
package rggen_native_initiator_pkg;

    localparam logic [1:0] RGGEN_READ         = 2'b10;
    localparam logic [1:0] RGGEN_WRITE        = 2'b01;
    localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b11;

    localparam logic [1:0] RGGEN_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_EXOKAY = 2'b01;
    localparam logic [1:0] RGGEN_SLVERR = 2'b10;
    localparam logic [1:0] RGGEN_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RSP  = 2'b10
    } state_e;

    // Counter must be able to hold the saturation value itself.
    function automatic int timer_width(input int cycles);
        if (cycles < 1) begin
            return 1;
        end else begin
            return $clog2(cycles + 1);
        end
    endfunction

endpackage

// File: rtl/rggen_native_initiator_timer.sv
// Saturating request-age counter; expire flags the last permitted cycle of a bus request.
module rggen_native_initiator_timer
    import rggen_native_initiator_pkg::*;
#(
    parameter int CYCLES = 8
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int            CW   = timer_width(CYCLES);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(CYCLES);

    logic [CW-1:0] count_r;

    // Age counter: cleared on request launch, counts bus cycles, holds at saturation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_r <= ZERO;
        end else if (i_clear) begin
            count_r <= ZERO;
        end else if (i_enable && (count_r != SAT)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // count_r equals the number of already-completed bus cycles, so LAST marks the final one.
    assign o_expire = i_enable && (count_r >= LAST);

endmodule

// File: rtl/rggen_native_initiator.sv
// Initiator end of the rggen native CSR bus: one access at a time, command in,
// request held on the bus until the ready pulse (or timeout), response out.
module rggen_native_initiator
    import rggen_native_initiator_pkg::*;
#(
    parameter int         ADDRESS_WIDTH  = 8,
    parameter int         BUS_WIDTH      = 32,
    parameter int         STROBE_WIDTH   = BUS_WIDTH / 8,
    parameter int         TIMEOUT_CYCLES = 0,
    parameter logic [1:0] TIMEOUT_STATUS = RGGEN_SLVERR
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_access,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [STROBE_WIDTH-1:0]  i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic                     o_rsp_timeout,
    output logic                     o_csrbus_valid,
    output logic [1:0]               o_csrbus_access,
    output logic [ADDRESS_WIDTH-1:0] o_csrbus_address,
    output logic [BUS_WIDTH-1:0]     o_csrbus_write_data,
    output logic [STROBE_WIDTH-1:0]  o_csrbus_strobe,
    input  logic                     i_csrbus_ready,
    input  logic [1:0]               i_csrbus_status,
    input  logic [BUS_WIDTH-1:0]     i_csrbus_read_data
);

    state_e state_r;
    logic   accept_s;
    logic   expire_s;

    assign accept_s = i_cmd_valid && o_cmd_ready;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timer
            assign expire_s = 1'b0;
        end else begin : g_timer
            rggen_native_initiator_timer #(
                .CYCLES (TIMEOUT_CYCLES)
            ) u_timer (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_clear  (accept_s),
                .i_enable (state_r == ST_BUS),
                .o_expire (expire_s)
            );
        end
    endgenerate

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r             <= ST_IDLE;
            o_cmd_ready         <= 1'b0;
            o_rsp_valid         <= 1'b0;
            o_rsp_status        <= RGGEN_OKAY;
            o_rsp_read_data     <= {BUS_WIDTH{1'b0}};
            o_rsp_timeout       <= 1'b0;
            o_csrbus_valid      <= 1'b0;
            o_csrbus_access     <= 2'b00;
            o_csrbus_address    <= {ADDRESS_WIDTH{1'b0}};
            o_csrbus_write_data <= {BUS_WIDTH{1'b0}};
            o_csrbus_strobe     <= {STROBE_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r             <= ST_BUS;
                        o_cmd_ready         <= 1'b0;
                        o_csrbus_valid      <= 1'b1;
                        o_csrbus_access     <= i_cmd_access;
                        o_csrbus_address    <= i_cmd_address;
                        o_csrbus_write_data <= i_cmd_write_data;
                        o_csrbus_strobe     <= i_cmd_strobe;
                    end else begin
                        o_cmd_ready <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // A ready arriving in the expiry cycle takes priority over the timeout.
                    if (i_csrbus_ready) begin
                        state_r         <= ST_RSP;
                        o_csrbus_valid  <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_status    <= i_csrbus_status;
                        o_rsp_read_data <= i_csrbus_read_data;
                        o_rsp_timeout   <= 1'b0;
                    end else if (expire_s) begin
                        state_r         <= ST_RSP;
                        o_csrbus_valid  <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_status    <= TIMEOUT_STATUS;
                        o_rsp_read_data <= {BUS_WIDTH{1'b0}};
                        o_rsp_timeout   <= 1'b1;
                    end else begin
                        state_r <= ST_BUS;
                    end
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        state_r     <= ST_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                    end else begin
                        state_r <= ST_RSP;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    o_cmd_ready    <= 1'b0;
                    o_rsp_valid    <= 1'b0;
                    o_csrbus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
